dma_uart_ctrl: RTL and testbench

- Sequences memory-to-UART DMA transfers for the peripheral at DMA_UART_ADDR (0x80000400).
- MIPS programs a source address and a byte count. The block then owns the bus through dma_mode/dma_write, fetches words from data memory, and streams bytes to UART TX.
- Signals completion via the EOT register and an interrupt line.
- Sits beside the address decoder and drives its dma_mode and dma_write inputs.

---
 rtl/dma_uart_ctrl_pkg.sv | 27 ++
 rtl/dma_uart_regs.sv | 80 ++++++++
 rtl/dma_uart_ctrl.sv | 109 ++++++++++
 tb/tb_dma_uart_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_uart_ctrl_pkg.sv
// rtl/dma_uart_ctrl_pkg.sv - shared DMA-to-UART register map, base address and FSM encoding
package dma_uart_ctrl_pkg;

  localparam logic [31:0] DMA_UART_ADDR = 32'h8000_0400;

  localparam logic [5:0] REG_DATA_OFS = 6'h00;
  localparam logic [5:0] REG_MODE_OFS = 6'h10;
  localparam logic [5:0] REG_EOT_OFS  = 6'h20;

  localparam int EOT_DONE_BIT   = 0;
  localparam int EOT_BUSY_BIT   = 1;
  localparam int MODE_ABORT_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } dma_state_t;

  function automatic logic [1:0] reg_sel(input logic [5:0] ofs);
    return ofs[5:4];
  endfunction

endpackage

// File: rtl/dma_uart_regs.sv
// rtl/dma_uart_regs.sv - DMA-to-UART register file, read mux, start/abort/clear strobes
// Optional abort on MODE bit31 while busy: DMA_UART_ABORT_EN
module dma_uart_regs
  import dma_uart_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_ce,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  input  logic                  idle,
  input  logic                  count_dec,
  input  logic                  set_done,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic [LEN_WIDTH-1:0]  count,
  output logic                  done,
  output logic                  start,
  output logic                  abort
);

  logic [ADDR_WIDTH-3:0] src_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic                  done_q;
  logic                  wr, wr_data, wr_mode, wr_eot;
  logic [1:0]            sel;
  logic                  unused_bits;

  assign sel     = cfg_addr[5:4];
  assign wr      = cfg_ce & cfg_we;
  assign wr_data = wr && (sel == reg_sel(REG_DATA_OFS));
  assign wr_mode = wr && (sel == reg_sel(REG_MODE_OFS));
  assign wr_eot  = wr && (sel == reg_sel(REG_EOT_OFS));
  assign start   = wr_mode && idle && (cfg_wdata[LEN_WIDTH-1:0] != '0);

`ifdef DMA_UART_ABORT_EN
  assign abort = wr_mode && !idle && cfg_wdata[MODE_ABORT_BIT];
`else
  assign abort = 1'b0;
`endif

  assign src_addr    = {src_q, 2'b00};
  assign count       = count_q;
  assign done        = done_q;
  assign unused_bits = ^{cfg_addr[ADDR_WIDTH-1:6], cfg_addr[3:0],
                         cfg_wdata[DATA_WIDTH-1:LEN_WIDTH], cfg_wdata[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      src_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (wr_data && idle) src_q <= cfg_wdata[ADDR_WIDTH-1:2];
      if (start) count_q <= cfg_wdata[LEN_WIDTH-1:0];
      else if (count_dec) count_q <= count_q - LEN_WIDTH'(1);
      // completion beats a coincident clear so an EOT can never be lost
      if (set_done) done_q <= 1'b1;
      else if (wr_eot) done_q <= 1'b0;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (sel == reg_sel(REG_DATA_OFS)) begin
      cfg_rdata = DATA_WIDTH'(src_addr);
    end else if (sel == reg_sel(REG_MODE_OFS)) begin
      cfg_rdata = DATA_WIDTH'(count_q);
    end else if (sel == reg_sel(REG_EOT_OFS)) begin
      cfg_rdata[EOT_DONE_BIT] = done_q;
      cfg_rdata[EOT_BUSY_BIT] = !idle;
    end
  end

endmodule

// File: rtl/dma_uart_ctrl.sv
// rtl/dma_uart_ctrl.sv - memory-to-UART DMA sequencer; fetches words and streams bytes big-endian
module dma_uart_ctrl
  import dma_uart_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_ce,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  output logic                  dma_mode,
  output logic                  dma_write,
  output logic                  mem_ce,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [7:0]            uart_data,
  output logic                  uart_start,
  input  logic                  uart_busy,
  output logic                  eot_irq
);

  dma_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [1:0]            byte_idx_q;
  logic                  first_q, abort_pend_q, abort_req;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [LEN_WIDTH-1:0]  count;
  logic                  done, start, abort, count_dec, set_done;

  dma_uart_regs #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) u_regs (
    .clock(clock), .reset(reset), .cfg_ce(cfg_ce), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .idle(state_q == ST_IDLE), .count_dec(count_dec), .set_done(set_done),
    .src_addr(src_addr), .count(count), .done(done), .start(start), .abort(abort)
  );

  assign abort_req = abort | abort_pend_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      buf_q        <= '0;
      byte_idx_q   <= '0;
      first_q      <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_q == ST_SEND) && (state_d == ST_WAIT_TX);
      if (start) begin
        ptr_q      <= src_addr;
        byte_idx_q <= '0;
      end
      if (state_q == ST_LATCH) begin
        buf_q <= mem_rdata;
        ptr_q <= ptr_q + ADDR_WIDTH'(4);
      end
      if (state_q == ST_WAIT_TX && state_d == ST_FETCH) byte_idx_q <= '0;
      else if (state_q == ST_WAIT_TX && state_d == ST_SEND) byte_idx_q <= byte_idx_q + 2'd1;
      // an abort landing in LATCH or busy WAIT_TX is held until it can be honoured
      if (state_q == ST_DONE) abort_pend_q <= 1'b0;
      else if (abort) abort_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_FETCH;
      ST_FETCH:   state_d = abort_req ? ST_DONE : ST_LATCH;
      ST_LATCH:   state_d = ST_SEND;
      ST_SEND: begin
        if (abort_req) state_d = ST_DONE;
        else if (!uart_busy) state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // uart_busy only rises the cycle after uart_start, so the first cycle is skipped
        if (!first_q && !uart_busy) begin
          if (abort_req || count == '0) state_d = ST_DONE;
          else if (byte_idx_q == 2'd3) state_d = ST_FETCH;
          else state_d = ST_SEND;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dma_mode   = (state_q != ST_IDLE);
    dma_write  = (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
    mem_ce     = (state_q == ST_FETCH);
    mem_addr   = (state_q == ST_FETCH) ? ptr_q : '0;
    uart_start = (state_q == ST_SEND) && !uart_busy && !abort_req;
    uart_data  = uart_start ? buf_q[{~byte_idx_q, 3'b000} +: 8] : 8'h00;
    count_dec  = uart_start;
    set_done   = (state_q == ST_DONE);
    eot_irq    = done;
  end

endmodule

// File: tb/tb_dma_uart_ctrl.sv
// tb/tb_dma_uart_ctrl.sv - scoreboard bench for dma_uart_ctrl with memory and UART TX models
module tb_dma_uart_ctrl;
  import dma_uart_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_ce, cfg_we;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
  logic        dma_mode, dma_write, mem_ce;
  logic [31:0] mem_addr, mem_rdata;
  logic [7:0]  uart_data;
  logic        uart_start, uart_busy, eot_irq;

  logic [31:0] mem [0:1023];
  int          busy_cnt = 0;
  int          n_checks = 0, n_pass = 0;
  int          n_starts = 0, n_fetch = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addrs[$];

  dma_uart_ctrl dut (
    .clock(clock), .reset(reset), .cfg_ce(cfg_ce), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .dma_mode(dma_mode), .dma_write(dma_write), .mem_ce(mem_ce),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .uart_data(uart_data),
    .uart_start(uart_start), .uart_busy(uart_busy), .eot_irq(eot_irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_rdata <= mem_ce ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clock) begin
    if (uart_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always begin
    @(negedge clock);
    #2;
    if (uart_start) begin
      n_starts++;
      check("start_while_busy", {31'b0, uart_busy}, 32'h0);
      check("byte_expected", {31'b0, exp_bytes.size() > 0}, 32'h1);
      if (exp_bytes.size() > 0) check("uart_byte", {24'b0, uart_data}, {24'b0, exp_bytes.pop_front()});
    end
    if (mem_ce) begin
      n_fetch++;
      check("fetch_expected", {31'b0, exp_addrs.size() > 0}, 32'h1);
      if (exp_addrs.size() > 0) check("mem_addr", mem_addr, exp_addrs.pop_front());
    end
  end

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    cfg_addr = addr; cfg_wdata = data; cfg_ce = 1'b1; cfg_we = 1'b1;
    @(negedge clock);
    cfg_ce = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
    cfg_addr = addr; cfg_ce = 1'b1; cfg_we = 1'b0;
    #1 data = cfg_rdata;
    cfg_ce = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    cfg_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic wait_eot(input int limit);
    logic found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (eot_irq) found = 1'b1;
    end
    check("eot_timeout", {31'b0, found}, 32'h1);
  endtask

  task automatic wait_state(input dma_state_t s, input int limit);
    logic found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (dut.state_q == s) found = 1'b1;
    end
    check("state_timeout", {31'b0, found}, 32'h1);
  endtask

  task automatic wait_starts(input int target, input int limit);
    logic found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (n_starts >= target) found = 1'b1;
    end
    check("start_timeout", {31'b0, found}, 32'h1);
  endtask

  task automatic push_word(input logic [31:0] w, input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_bytes.push_back(w[31-8*i -: 8]);
  endtask

  int base;

  initial begin
    reset = 1'b1; cfg_ce = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h4142_4344; mem[32'h104 >> 2] = 32'h4546_4748;
    mem[32'h200 >> 2] = 32'h1122_3344; mem[32'h204 >> 2] = 32'h5566_7788;
    mem[32'h208 >> 2] = 32'h99AA_BBCC; mem[32'h300 >> 2] = 32'hDEAD_BEEF;
    mem[32'h304 >> 2] = 32'hCAFE_F00D; mem[32'h400 >> 2] = 32'hA1A2_A3A4;
    mem[32'h404 >> 2] = 32'hB1B2_B3B4;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_dma_mode", {31'b0, dma_mode}, 32'h0);
    check("rst_dma_write", {31'b0, dma_write}, 32'h0);
    check("rst_mem_ce", {31'b0, mem_ce}, 32'h0);
    check("rst_uart_start", {31'b0, uart_start}, 32'h0);
    check("rst_eot_irq", {31'b0, eot_irq}, 32'h0);
    read_check("rst_data", 32'h00, 32'h0);
    read_check("rst_mode", 32'h10, 32'h0);
    read_check("rst_eot", 32'h20, 32'h0);

    // basic 4-byte transfer
    base = n_starts;
    push_word(32'h4142_4344, 4); exp_addrs.push_back(32'h100);
    cfg_write(32'h00, 32'h100);
    cfg_write(32'h10, 32'd4);
    wait_eot(400);
    check("basic_starts", n_starts - base, 32'd4);
    check("basic_bytes_left", exp_bytes.size(), 32'd0);
    check("basic_fetch_left", exp_addrs.size(), 32'd0);
    check("basic_dma_mode", {31'b0, dma_mode}, 32'h0);
    read_check("basic_eot", 32'h20, 32'h1);
    read_check("basic_mode", 32'h10, 32'h0);
    read_check("basic_data", 32'h00, 32'h100);
    cfg_write(32'h20, 32'h0);
    check("clr_irq", {31'b0, eot_irq}, 32'h0);
    read_check("clr_eot", 32'h20, 32'h0);

    // partial final word, unaligned source
    base = n_starts;
    push_word(32'h1122_3344, 4); push_word(32'h5566_7788, 2);
    exp_addrs.push_back(32'h200); exp_addrs.push_back(32'h204);
    cfg_write(32'h00, 32'h203);
    read_check("part_data_aligned", 32'h00, 32'h200);
    cfg_write(32'h10, 32'd6);
    wait_eot(400);
    check("part_starts", n_starts - base, 32'd6);
    check("part_bytes_left", exp_bytes.size(), 32'd0);
    check("part_fetch_left", exp_addrs.size(), 32'd0);
    cfg_write(32'h20, 32'h0);

    // zero length does not start
    base = n_fetch;
    cfg_write(32'h10, 32'd0);
    repeat (5) @(negedge clock);
    check("zero_dma_mode", {31'b0, dma_mode}, 32'h0);
    check("zero_fetch", n_fetch - base, 32'd0);
    read_check("zero_eot", 32'h20, 32'h0);

    // writes while busy ignored, then EOT clear races DONE
    base = n_starts;
    push_word(32'hA1A2_A3A4, 4); push_word(32'hB1B2_B3B4, 4);
    exp_addrs.push_back(32'h400); exp_addrs.push_back(32'h404);
    cfg_write(32'h00, 32'h400);
    cfg_write(32'h10, 32'd8);
    repeat (3) @(negedge clock);
    cfg_write(32'h00, 32'h300);
    cfg_write(32'h10, 32'd2);
    read_check("busy_data_kept", 32'h00, 32'h400);
    read_check("busy_eot", 32'h20, 32'h2);
    wait_state(ST_DONE, 400);
    cfg_write(32'h20, 32'h0);
    check("race_irq", {31'b0, eot_irq}, 32'h1);
    read_check("race_eot", 32'h20, 32'h1);
    check("busy_starts", n_starts - base, 32'd8);
    check("busy_bytes_left", exp_bytes.size(), 32'd0);
    check("busy_fetch_left", exp_addrs.size(), 32'd0);
    cfg_write(32'h20, 32'h0);
    check("later_clr_irq", {31'b0, eot_irq}, 32'h0);
    read_check("later_clr_eot", 32'h20, 32'h0);

    // reset during WAIT_TX of byte 2
    base = n_starts;
    push_word(32'h4142_4344, 2); exp_addrs.push_back(32'h100);
    cfg_write(32'h00, 32'h100);
    cfg_write(32'h10, 32'd8);
    wait_starts(base + 2, 200);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_dma_mode", {31'b0, dma_mode}, 32'h0);
    check("mid_rst_start", {31'b0, uart_start}, 32'h0);
    read_check("mid_rst_mode", 32'h10, 32'h0);
    read_check("mid_rst_eot", 32'h20, 32'h0);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    check("mid_rst_starts", n_starts - base, 32'd2);
    check("mid_rst_bytes_left", exp_bytes.size(), 32'd0);
    check("mid_rst_idle", {31'b0, dma_mode}, 32'h0);

    // abort request during SEND of byte 3
    base = n_starts;
`ifdef DMA_UART_ABORT_EN
    push_word(32'h4142_4344, 2); exp_addrs.push_back(32'h100);
`else
    push_word(32'h4142_4344, 4); push_word(32'h4546_4748, 4);
    exp_addrs.push_back(32'h100); exp_addrs.push_back(32'h104);
`endif
    cfg_write(32'h00, 32'h100);
    cfg_write(32'h10, 32'd8);
    wait_starts(base + 2, 200);
    wait_state(ST_SEND, 100);
    cfg_write(32'h10, 32'h8000_0000);
    wait_eot(400);
    repeat (20) @(negedge clock);
`ifdef DMA_UART_ABORT_EN
    check("abort_starts", n_starts - base, 32'd2);
    read_check("abort_mode", 32'h10, 32'd6);
`else
    check("abort_starts", n_starts - base, 32'd8);
    read_check("abort_mode", 32'h10, 32'd0);
`endif
    check("abort_irq", {31'b0, eot_irq}, 32'h1);
    check("abort_bytes_left", exp_bytes.size(), 32'd0);
    check("abort_fetch_left", exp_addrs.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
